// File: rtl/id_ex_pkg.sv
// id_ex_pkg: widths and bubble encoding shared by id, id_ex and ex
package id_ex_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/id_ex_pipe_entry.sv
// id_ex_pipe_entry: valid bit plus payload register with load and clear
module id_ex_pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= clr ? 1'b0 : load ? 1'b1 : valid;
      if (load) q <= d;
    end
endmodule

// File: rtl/id_ex.sv
// id_ex: decode-to-execute pipeline register with 2-entry skid buffer and flush
module id_ex
  import id_ex_pkg::*;
#(
  parameter int          DW       = DATA_W,
  parameter int          RW       = REG_W,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] inst_i,
  input  logic [DW-1:0] inst_addr_i,
  input  logic [DW-1:0] op1_i,
  input  logic [DW-1:0] op2_i,
  input  logic [RW-1:0] rd_addr_i,
  input  logic          rd_wen_i,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] inst_o,
  output logic [DW-1:0] inst_addr_o,
  output logic [DW-1:0] op1_o,
  output logic [DW-1:0] op2_o,
  output logic [RW-1:0] rd_addr_o,
  output logic          rd_wen_o
);
  localparam int PW = 4 * DW + RW + 1;
  logic [PW-1:0] in_b, m_d, m_q, s_q;
  logic [DW-1:0] m_inst;
  logic m_valid, s_valid, m_wen, acc, con, m_load, m_clr, s_load, s_clr;
  assign in_b      = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i};
  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign acc       = in_valid & in_ready;
  assign con       = m_valid & out_ready;
  // S only ever fills behind a full M, so a full S is always the next bundle for M
  always_comb begin
    m_d    = s_valid ? s_q : in_b;
    m_load = !flush & (m_valid ? con & (s_valid | acc) : acc);
    m_clr  = flush | (con & !s_valid & !acc);
    s_load = !flush & m_valid & !con & acc;
    s_clr  = flush | (con & s_valid);
  end
  id_ex_pipe_entry #(.W(PW)) u_m (
    .clk(clk), .rst_n(rst_n), .load(m_load), .clr(m_clr), .d(m_d), .valid(m_valid), .q(m_q)
  );
  id_ex_pipe_entry #(.W(PW)) u_s (
    .clk(clk), .rst_n(rst_n), .load(s_load), .clr(s_clr), .d(in_b), .valid(s_valid), .q(s_q)
  );
  assign {m_inst, inst_addr_o, op1_o, op2_o, rd_addr_o, m_wen} = m_q;
  assign inst_o   = m_valid ? m_inst : NOP_INST;
  assign rd_wen_o = m_valid & m_wen;
endmodule

// File: tb/tb_id_ex.sv
// tb_id_ex: scoreboard bench for the id_ex skid-buffered pipeline register
module tb_id_ex;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int PW = 4 * DW + RW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic in_ready, out_valid, rd_wen_i = 1'b0, rd_wen_o;
  logic [DW-1:0] inst_i = '0, inst_addr_i = '0, op1_i = '0, op2_i = '0;
  logic [DW-1:0] inst_o, inst_addr_o, op1_o, op2_o;
  logic [RW-1:0] rd_addr_i = '0, rd_addr_o;
  logic [PW-1:0] sb[$];
  int n_chk = 0, n_fail = 0;

  id_ex dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
    .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
    .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_b();
    return {$urandom(), $urandom(), $urandom(), $urandom(), RW'($urandom()), 1'($urandom())};
  endfunction

  // Called just after a rising edge: checks the current outputs, drives one cycle, advances.
  task automatic cyc(input logic iv, input logic ordy, input logic fl, input logic [PW-1:0] b);
    logic acc, con;
    if (!out_valid) begin
      chk("bubble_wen", PW'(rd_wen_o), PW'(0));
      chk("bubble_inst", PW'(inst_o), PW'(NOP));
    end
    in_valid = iv;
    out_ready = ordy;
    flush = fl;
    {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i} = b;
    acc = iv & in_ready;
    con = out_valid & ordy;
    if (fl) sb.delete();
    else begin
      if (con) begin
        chk("sb_nonempty", PW'(sb.size() != 0), PW'(1));
        if (sb.size() != 0)
          chk("sb_data", {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o}, sb.pop_front());
      end
      if (acc) sb.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, rnd_b());
    chk("drain_empty", PW'(sb.size()), PW'(0));
  endtask

  logic [PW-1:0] bun_a, bun_b, bun_c, addi;

  initial begin
    addi = {32'h0050_0093, 32'h0000_0100, 32'd0, 32'd5, 5'd1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i} = rnd_b();
      in_valid = 1'($urandom());
      out_ready = 1'($urandom());
      @(posedge clk);
      #1;
    end
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_inst", PW'(inst_o), PW'(NOP));
    chk("rst_wen", PW'(rd_wen_o), PW'(0));
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    chk("rst_addr", PW'(inst_addr_o), PW'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cyc(1'b1, 1'b1, 1'b0, addi);
    chk("stream_valid", PW'(out_valid), PW'(1));
    chk("stream_bundle", {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o}, addi);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 1'b0, rnd_b());
      chk("stream_ready", PW'(in_ready), PW'(1));
      chk("stream_rate", PW'(out_valid), PW'(1));
    end
    drain();

    bun_a = rnd_b();
    bun_b = rnd_b();
    cyc(1'b1, 1'b0, 1'b0, bun_a);
    cyc(1'b1, 1'b0, 1'b0, bun_b);
    chk("bp_in_ready", PW'(in_ready), PW'(0));
    chk("bp_hold_a", {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o}, bun_a);
    cyc(1'b0, 1'b0, 1'b0, rnd_b());
    chk("bp_still_a", {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o}, bun_a);
    cyc(1'b0, 1'b1, 1'b0, rnd_b());
    chk("bp_b_next", {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o}, bun_b);
    chk("bp_ready_back", PW'(in_ready), PW'(1));
    drain();

    bun_c = rnd_b();
    bun_c[0] = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, rnd_b());
    cyc(1'b1, 1'b0, 1'b0, rnd_b());
    chk("fl_pre_full", PW'(in_ready), PW'(0));
    cyc(1'b1, 1'b0, 1'b1, bun_c);
    chk("fl_out_valid", PW'(out_valid), PW'(0));
    chk("fl_inst", PW'(inst_o), PW'(NOP));
    chk("fl_wen", PW'(rd_wen_o), PW'(0));
    chk("fl_in_ready", PW'(in_ready), PW'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, rnd_b());
      chk("fl_no_c", PW'(out_valid), PW'(0));
    end
    cyc(1'b1, 1'b1, 1'b1, bun_c);
    chk("fl_accept_dropped", PW'(out_valid), PW'(0));

    cyc(1'b1, 1'b0, 1'b0, rnd_b());
    cyc(1'b1, 1'b0, 1'b0, rnd_b());
    chk("ar_pre_full", PW'(in_ready), PW'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", PW'(out_valid), PW'(0));
    chk("ar_inst", PW'(inst_o), PW'(NOP));
    chk("ar_wen", PW'(rd_wen_o), PW'(0));
    chk("ar_in_ready", PW'(in_ready), PW'(1));
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom()), 1'($urandom()), 1'($urandom_range(0, 199) == 0), rnd_b());
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
